// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter granting NREQ requesters burst write
// access to a bank of NREG data registers. Each accepted write becomes a
// registered one-cycle reg_we pulse with reg_wdata on the following clock.
module reg_write_arbiter #(
   parameter int NREQ      = 4,
   parameter int GW        = 2,
   parameter int NREG      = 4,
   parameter int AW        = 2,
   parameter int DW        = 8,
   parameter int MAX_BURST = 4,
   parameter int TIMEOUT   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_data,
   input  logic [NREQ-1:0]      req_last,
   output logic [NREQ-1:0]      req_ready,
   output logic [NREG-1:0]      reg_we,
   output logic [DW-1:0]        reg_wdata,
   output logic [GW-1:0]        grant_id,
   output logic                 busy,
   output logic                 err
);

   // Beat and idle counters are sized for limits up to 15.
   localparam int CW = 4;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [GW-1:0]   r_ptr, w_ptr_nxt;
   logic [GW-1:0]   r_grant, w_grant_nxt;
   logic [CW-1:0]   r_beat, w_beat_nxt;
   logic [CW-1:0]   r_idle, w_idle_nxt;
   logic            r_busy, w_busy_nxt;
   logic [NREG-1:0] r_we, w_we_nxt;
   logic [DW-1:0]   r_wdata, w_wdata_nxt;
   logic            r_err, w_err_nxt;

   logic [GW-1:0]   w_winner;
   logic            w_found;
   logic            w_own_valid;
   logic            w_own_last;
   logic [AW-1:0]   w_own_addr;
   logic [DW-1:0]   w_own_data;
   logic            w_xfer;
   logic            w_addr_ok;

   // Owner's request fields, selected by the registered grant only.
   assign w_own_valid = req_valid[r_grant];
   assign w_own_last  = req_last[r_grant];
   assign w_own_addr  = req_addr[r_grant*AW +: AW];
   assign w_own_data  = req_data[r_grant*DW +: DW];
   assign w_xfer      = (r_state == ST_OWN) && w_own_valid;
   assign w_addr_ok   = (int'(w_own_addr) < NREG);

   // Ready decode: depends on registered state only, never on req_valid.
   always_comb begin
      req_ready = '0;
      if (r_state == ST_OWN) begin
         req_ready[r_grant] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   // Round-robin search: first valid requester at or after the pointer.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_found && req_valid[(int'(r_ptr) + k) % NREQ]) begin
            w_found  = 1'b1;
            w_winner = GW'((int'(r_ptr) + k) % NREQ);
         end else begin
            w_found  = w_found;
         end
      end
   end

   // Next-state, counters and registered-output values.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_grant_nxt = r_grant;
      w_beat_nxt  = r_beat;
      w_idle_nxt  = r_idle;
      w_busy_nxt  = r_busy;
      w_we_nxt    = '0;
      w_wdata_nxt = r_wdata;
      w_err_nxt   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_nxt = ST_OWN;
               w_grant_nxt = w_winner;
               w_busy_nxt  = 1'b1;
               w_beat_nxt  = '0;
               w_idle_nxt  = '0;
            end else begin
               w_busy_nxt  = 1'b0;
            end
         end
         ST_OWN: begin
            if (w_xfer) begin
               w_beat_nxt = r_beat + CW'(1);
               w_idle_nxt = '0;
               if (w_addr_ok) begin
                  for (int i = 0; i < NREG; i++) begin
                     w_we_nxt[i] = (int'(w_own_addr) == i);
                  end
                  w_wdata_nxt = w_own_data;
               end else begin
                  w_err_nxt = 1'b1;
               end
               if (w_own_last || (w_beat_nxt == CW'(MAX_BURST))) begin
                  w_state_nxt = ST_IDLE;
                  w_busy_nxt  = 1'b0;
                  w_ptr_nxt   = GW'((int'(r_grant) + 1) % NREQ);
                  w_beat_nxt  = '0;
                  w_idle_nxt  = '0;
               end else begin
                  w_state_nxt = ST_OWN;
               end
            end else begin
               w_idle_nxt = r_idle + CW'(1);
               if (w_idle_nxt == CW'(TIMEOUT)) begin
                  w_state_nxt = ST_IDLE;
                  w_busy_nxt  = 1'b0;
                  w_ptr_nxt   = GW'((int'(r_grant) + 1) % NREQ);
                  w_beat_nxt  = '0;
                  w_idle_nxt  = '0;
               end else begin
                  w_state_nxt = ST_OWN;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
            w_beat_nxt  = '0;
            w_idle_nxt  = '0;
         end
      endcase
   end

   // State and output registers; reset abandons any burst in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_grant <= '0;
         r_beat  <= '0;
         r_idle  <= '0;
         r_busy  <= 1'b0;
         r_we    <= '0;
         r_wdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_grant <= w_grant_nxt;
         r_beat  <= w_beat_nxt;
         r_idle  <= w_idle_nxt;
         r_busy  <= w_busy_nxt;
         r_we    <= w_we_nxt;
         r_wdata <= w_wdata_nxt;
         r_err   <= w_err_nxt;
      end
   end

   assign reg_we    = r_we;
   assign reg_wdata = r_wdata;
   assign grant_id  = r_grant;
   assign busy      = r_busy;
   assign err       = r_err;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level ownership model of the arbiter.
module tb_reg_write_arbiter;

   localparam int NREQ = 4, GW = 2, NREG = 4, AW = 2, DW = 8;
   localparam int MAX_BURST = 4, TIMEOUT = 8;

   logic        clk, rst_n;
   logic [3:0]  tb_valid, tb_last;
   logic [7:0]  tb_addr;
   logic [31:0] tb_data;

   logic [3:0]  ready, we;
   logic [7:0]  wdata;
   logic [1:0]  gid;
   logic        busy, err;

   logic [3:0]  ready3;
   logic [2:0]  we3;
   logic [7:0]  wdata3;
   logic [1:0]  gid3;
   logic        busy3, err3;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: who owns the bank and what the bank side shows
   bit         m_own, m_busy, m_err, m_xfer;
   int         m_owner, m_ptr, m_beat, m_idle, m_gid;
   logic [3:0] m_we;
   logic [7:0] m_wdata;

   reg_write_arbiter #(.NREQ(NREQ), .GW(GW), .NREG(NREG), .AW(AW), .DW(DW),
                       .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(tb_valid), .req_addr(tb_addr),
      .req_data(tb_data), .req_last(tb_last), .req_ready(ready), .reg_we(we),
      .reg_wdata(wdata), .grant_id(gid), .busy(busy), .err(err));

   reg_write_arbiter #(.NREQ(NREQ), .GW(GW), .NREG(3), .AW(AW), .DW(DW),
                       .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)) dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(tb_valid), .req_addr(tb_addr),
      .req_data(tb_data), .req_last(tb_last), .req_ready(ready3), .reg_we(we3),
      .reg_wdata(wdata3), .grant_id(gid3), .busy(busy3), .err(err3));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [3:0] m_ready();
      return m_own ? (4'b0001 << m_owner) : 4'b0000;
   endfunction

   task automatic model_reset();
      m_own = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_xfer = 1'b0;
      m_owner = 0; m_ptr = 0; m_beat = 0; m_idle = 0; m_gid = 0;
      m_we = 4'b0000; m_wdata = 8'h00;
   endtask

   task automatic model_release();
      m_own = 1'b0;
      m_ptr = (m_owner + 1) % NREQ;
      m_beat = 0;
      m_idle = 0;
   endtask

   // one clock of the ownership rules, using the inputs present at the edge
   task automatic model_step();
      int w, a;
      m_we = 4'b0000; m_err = 1'b0; m_xfer = 1'b0;
      if (!m_own) begin
         w = -1;
         for (int k = 0; k < NREQ; k++)
            if (w < 0 && tb_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
         if (w >= 0) begin
            m_own = 1'b1; m_owner = w; m_gid = w; m_beat = 0; m_idle = 0;
         end
      end else if (tb_valid[m_owner]) begin
         m_xfer = 1'b1;
         m_idle = 0;
         m_beat = m_beat + 1;
         a = int'(tb_addr[m_owner*AW +: AW]);
         if (a < NREG) begin
            m_we = 4'b0001 << a;
            m_wdata = tb_data[m_owner*DW +: DW];
         end else begin
            m_err = 1'b1;
         end
         if (tb_last[m_owner] || m_beat == MAX_BURST) model_release();
      end else begin
         m_idle = m_idle + 1;
         if (m_idle == TIMEOUT) model_release();
      end
      m_busy = m_own;
   endtask

   // advance one clock; inputs change and outputs are sampled at negedge
   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset(); else model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tb_valid = 4'b0000; tb_last = 4'b0000; tb_addr = 8'h00; tb_data = 32'h0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tb_valid = 4'b1111; tb_last = 4'b0000; tb_addr = 8'hFF; tb_data = 32'hFFFF_FFFF;
      model_reset();
      @(negedge clk);
      n_tests++; if (we !== 4'b0000) begin n_fail++; $display("FAIL reset_we got %b want 0000", we); end
      n_tests++; if (wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata got %h want 00", wdata); end
      n_tests++; if (gid !== 2'd0) begin n_fail++; $display("FAIL reset_gid got %0d want 0", gid); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
      n_tests++; if (ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b want 0000", ready); end
      do_reset();
   endtask

   task automatic test_single_write();
      do_reset();
      tb_valid = 4'b0100; tb_last = 4'b0100;
      tb_addr[5:4] = 2'd1; tb_data[23:16] = 8'hA5;
      n_tests++; if (ready !== 4'b0000) begin n_fail++; $display("FAIL single_arb_ready got %b want 0000", ready); end
      tick();
      n_tests++; if (ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got %b want 0100", ready); end
      n_tests++; if (busy !== 1'b1 || gid !== 2'd2) begin n_fail++; $display("FAIL single_grant got busy=%b gid=%0d want busy=1 gid=2", busy, gid); end
      n_tests++; if (we !== 4'b0000) begin n_fail++; $display("FAIL single_arb_we got %b want 0000", we); end
      tick();
      tb_valid = 4'b0000;
      n_tests++; if (we !== 4'b0010 || wdata !== 8'hA5) begin n_fail++; $display("FAIL single_write got we=%b data=%h want we=0010 data=a5", we, wdata); end
      n_tests++; if (busy !== 1'b0 || gid !== 2'd2) begin n_fail++; $display("FAIL single_release got busy=%b gid=%0d want busy=0 gid=2", busy, gid); end
      tick();
      n_tests++; if (we !== 4'b0000) begin n_fail++; $display("FAIL single_pulse_len got %b want 0000", we); end
   endtask

   task automatic test_round_robin();
      int r;
      do_reset();
      tb_valid = 4'b1111; tb_last = 4'b1111;
      for (int o = 0; o < 5; o++) begin
         tb_addr = 8'($urandom); tb_data = $urandom;
         r = o % NREQ;
         tick();
         n_tests++; if (gid !== 2'(r) || busy !== 1'b1 || ready !== (4'b0001 << r)) begin
            n_fail++; $display("FAIL rr_grant%0d got gid=%0d busy=%b ready=%b want gid=%0d", o, gid, busy, ready, r); end
         n_tests++; if (we !== 4'b0000) begin n_fail++; $display("FAIL rr_arb_we%0d got %b want 0000", o, we); end
         tick();
         n_tests++; if (we !== (4'b0001 << tb_addr[r*AW +: AW]) || wdata !== tb_data[r*DW +: DW] || busy !== 1'b0) begin
            n_fail++; $display("FAIL rr_write%0d got we=%b data=%h busy=%b want we=%b data=%h busy=0",
                               o, we, wdata, busy, 4'b0001 << tb_addr[r*AW +: AW], tb_data[r*DW +: DW]); end
      end
      tb_valid = 4'b0000;
      tick();
   endtask

   task automatic test_max_burst();
      logic [7:0] got[$];
      int idx;
      do_reset();
      idx = 1;
      tb_valid = 4'b0010; tb_last = 4'b0000;
      tb_addr[3:2] = 2'd2; tb_data[15:8] = 8'(idx);
      for (int c = 0; c < 12; c++) begin
         tick();
         if (we !== 4'b0000) got.push_back(wdata);
         if (m_xfer) begin
            if (idx == 4) begin
               n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL burst_release got busy=%b want 0", busy); end
            end
            idx++;
            tb_data[15:8] = 8'(idx);
            if (idx == 6) tb_last[1] = 1'b1;
            if (idx > 6) tb_valid = 4'b0000;
         end
      end
      n_tests++; if (got.size() != 6) begin n_fail++; $display("FAIL burst_count got %0d want 6", got.size()); end
      for (int k = 0; k < got.size() && k < 6; k++) begin
         n_tests++; if (got[k] !== 8'(k + 1)) begin n_fail++; $display("FAIL burst_data%0d got %h want %h", k, got[k], 8'(k + 1)); end
      end
   endtask

   task automatic test_timeout();
      do_reset();
      tb_valid = 4'b1001; tb_last = 4'b1000;
      tb_addr = 8'b01_00_00_00; tb_data = 32'h5A00_0011;
      tick();
      n_tests++; if (gid !== 2'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL to_grant0 got gid=%0d busy=%b want gid=0 busy=1", gid, busy); end
      tick();
      tb_valid[0] = 1'b0;
      n_tests++; if (we !== 4'b0001 || wdata !== 8'h11) begin n_fail++; $display("FAIL to_write got we=%b data=%h want 0001 11", we, wdata); end
      for (int i = 1; i <= TIMEOUT; i++) begin
         tick();
         if (i < TIMEOUT) begin
            n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL to_hold%0d got busy=%b want 1", i, busy); end
         end else begin
            n_tests++; if (busy !== 1'b0 || gid !== 2'd0) begin n_fail++; $display("FAIL to_release got busy=%b gid=%0d want busy=0 gid=0", busy, gid); end
         end
      end
      tick();
      n_tests++; if (gid !== 2'd3 || busy !== 1'b1 || ready !== 4'b1000) begin
         n_fail++; $display("FAIL to_grant3 got gid=%0d busy=%b ready=%b want 3 1 1000", gid, busy, ready); end
      tick();
      tb_valid = 4'b0000;
      n_tests++; if (we !== 4'b0010 || wdata !== 8'h5A) begin n_fail++; $display("FAIL to_write3 got we=%b data=%h want 0010 5a", we, wdata); end
   endtask

   task automatic test_bad_addr();
      do_reset();
      tb_valid = 4'b0001; tb_last = 4'b0001;
      tb_addr[1:0] = 2'd3; tb_data[7:0] = 8'h77;
      tick();
      n_tests++; if (ready3 !== 4'b0001) begin n_fail++; $display("FAIL bad_ready got %b want 0001", ready3); end
      tick();
      tb_valid = 4'b0000;
      n_tests++; if (err3 !== 1'b1) begin n_fail++; $display("FAIL bad_err got %b want 1", err3); end
      n_tests++; if (we3 !== 3'b000 || wdata3 !== 8'h00) begin n_fail++; $display("FAIL bad_we got we=%b data=%h want 000 00", we3, wdata3); end
      n_tests++; if (busy3 !== 1'b0 || gid3 !== 2'd0) begin n_fail++; $display("FAIL bad_release got busy=%b gid=%0d want 0 0", busy3, gid3); end
      n_tests++; if (we !== 4'b1000 || err !== 1'b0) begin n_fail++; $display("FAIL bad_ref4 got we=%b err=%b want 1000 0", we, err); end
      tick();
      n_tests++; if (err3 !== 1'b0) begin n_fail++; $display("FAIL bad_err_len got %b want 0", err3); end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      tb_valid = 4'b0100; tb_last = 4'b0000;
      tb_addr[5:4] = 2'd2; tb_data[23:16] = 8'h3C;
      tick();
      n_tests++; if (ready !== 4'b0100) begin n_fail++; $display("FAIL mid_ready got %b want 0100", ready); end
      tb_valid = 4'b0101;
      rst_n = 1'b0;
      #1;
      n_tests++; if (we !== 4'b0000 || wdata !== 8'h00 || gid !== 2'd0 || busy !== 1'b0 || err !== 1'b0 || ready !== 4'b0000) begin
         n_fail++; $display("FAIL mid_async got we=%b data=%h gid=%0d busy=%b err=%b ready=%b want all 0", we, wdata, gid, busy, err, ready); end
      tick();
      rst_n = 1'b1;
      n_tests++; if (we !== 4'b0000) begin n_fail++; $display("FAIL mid_no_we got %b want 0000", we); end
      tick();
      n_tests++; if (we !== 4'b0000 || gid !== 2'd0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL mid_restart got we=%b gid=%0d busy=%b want 0000 0 1", we, gid, busy); end
      tb_valid = 4'b0000;
      tick();
      tick();
   endtask

   task automatic test_random();
      int thr_v, thr_l;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         if (c % 100 == 0) begin
            thr_v = $urandom_range(1, 8);
            thr_l = $urandom_range(0, 4);
         end
         for (int i = 0; i < NREQ; i++) begin
            tb_valid[i] = ($urandom_range(0, 7) < thr_v);
            tb_last[i]  = ($urandom_range(0, 7) < thr_l);
         end
         tb_addr = 8'($urandom);
         tb_data = $urandom;
         n_tests++; if (ready !== m_ready()) begin n_fail++; $display("FAIL rnd_ready c=%0d got %b want %b", c, ready, m_ready()); end
         tick();
         n_tests++; if (we !== m_we) begin n_fail++; $display("FAIL rnd_we c=%0d got %b want %b", c, we, m_we); end
         n_tests++; if (m_we != 4'b0000 && wdata !== m_wdata) begin n_fail++; $display("FAIL rnd_wdata c=%0d got %h want %h", c, wdata, m_wdata); end
         n_tests++; if (busy !== m_busy || gid !== 2'(m_gid)) begin
            n_fail++; $display("FAIL rnd_own c=%0d got busy=%b gid=%0d want busy=%b gid=%0d", c, busy, gid, m_busy, m_gid); end
         n_tests++; if (err !== m_err) begin n_fail++; $display("FAIL rnd_err c=%0d got %b want %b", c, err, m_err); end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      tb_valid = 4'b0000; tb_last = 4'b0000; tb_addr = 8'h00; tb_data = 32'h0;
      model_reset();
      test_reset();
      test_single_write();
      test_round_robin();
      test_max_burst();
      test_timeout();
      test_bad_addr();
      test_reset_mid_burst();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Round-robin arbiter that shares write access to a bank of NREG 8-bit data registers among NREQ requesters.
- Each registered requester owns the bank for a burst of writes. Each accepted write becomes a one-cycle write-enable pulse plus write data on the register-bank side.
- Sits between the control agents and the 8-bit register bank; the bank registers reset asynchronously to 0.

Parameters:
- NREQ, 4, number of requesters
- GW, 2, width of grant_id (log2 NREQ)
- NREG, 4, number of target registers
- AW, 2, address width per requester
- DW, 8, data width
- MAX_BURST, 4, max accepted writes per ownership (1..15)
- TIMEOUT, 8, idle cycles of owner before forced release (1..15)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester write request valid
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_data  in  NREQ*DW  packed data, requester i at [i*DW +: DW]
- req_last  in  NREQ  marks final write of requester's burst
- req_ready  out  NREQ  accept strobe; write transfers when valid&ready
- reg_we  out  NREG  one-hot write enable to register bank, registered
- reg_wdata  out  DW  write data to register bank, registered
- grant_id  out  GW  current/last owner index
- busy  out  1  high while an owner holds the bank
- err  out  1  one-cycle pulse: accepted write had addr >= NREG

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE, rr pointer=0, beat/idle counters=0.
  - reg_we=0, reg_wdata=0, grant_id=0, busy=0, err=0.
  - req_ready=0.
- Reset mid-burst: burst abandoned; no reg_we pulse for a write accepted in the cycle reset asserts.
- IDLE state:
  - If any req_valid is set, pick the first set bit searching from ptr upward, wrapping mod NREQ.
  - Register grant_id=winner, busy=1, go to OWN.
  - Otherwise stay in IDLE.
  - The arbitration cycle never accepts data.
- OWN state:
  - req_ready[i] = (state==OWN && grant_id==i), combinational from registers only (no path from req_valid).
  - Transfer = req_valid[owner] & req_ready[owner].
  - On transfer, the next cycle drives reg_wdata=data and reg_we[addr]=1 (exactly one bit) for one cycle. Latency handshake->we = 1 clock.
  - If addr >= NREG: transfer still accepted, reg_we stays 0, reg_wdata unchanged, err=1 next cycle.
  - beat counter increments per transfer.
  - idle counter increments each OWN cycle without owner valid, clears on owner valid.
- Release from OWN (to IDLE, busy=0 next cycle, ptr=(owner+1) mod NREQ), on whichever comes first:
  - a transfer with req_last=1;
  - the transfer that makes beat == MAX_BURST;
  - idle counter reaching TIMEOUT.
- After release:
  - grant_id holds the last owner value.
  - Counters clear.
  - Releasing cycle's reg_we pulse still occurs.
- Fairness: with all requesters continuously valid, ownership order is 0,1,2,3,0,… Any valid requester waits at most NREQ-1 ownerships.
- Non-owner req_valid is ignored; its signals may change freely.
- Owner dropping valid mid-burst keeps ownership until TIMEOUT.
- Throughput: MAX_BURST writes per MAX_BURST+1 cycles under continuous traffic.
- reg_we is all-zero every cycle except the cycle after a valid-address transfer; never more than one bit set.

Test Plan:
- Reset, then req_valid[2]=1, addr=1, data=0xA5, last=1 -> arb cycle, req_ready[2]=1 next cycle; one cycle later reg_we=4'b0010, reg_wdata=0xA5; busy falls; grant_id stays 2.
- req_valid=4'b1111 held, all last=1 -> grant order 0,1,2,3,0; each ownership 2 cycles; one reg_we pulse per ownership.
- Requester 1 holds valid with last=0 and data 0x01..0x06 -> exactly 4 writes accepted (MAX_BURST), release, re-arbitration, remaining writes in next ownership.
- Requester 0 granted, drops valid after 1 write -> released after 8 idle cycles (TIMEOUT); requester 3 waiting is then granted.
- Owner sends addr=3 with NREG=3 override -> accepted, err pulses 1 cycle, reg_we stays 0.
- rst_n asserted in the same cycle as a transfer of 0x3C -> all outputs 0 immediately; no reg_we pulse after rst_n=1; ptr restarts at 0.
